fpga_cfg_loader: RTL and testbench
==================================

Name: fpga_cfg_loader

Overview:
- Configuration front-end sitting directly upstream of the logic_cell array.
- Accepts a byte-wide bitstream over a valid/ready handshake and serialises it onto the configuration shift chain. That chain carries each cell's LUT contents plus its mux_sync/mux_carry bits.
- Holds the cells in reset until the full payload has been shifted and validated, then releases them.

Parameters:
- NUM_CELLS, 4, number of logic cells on the configuration chain.
- CFG_W, 18, configuration bits per cell (16 LUT bits + mux_sync + mux_carry).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous reset, active high
- start_i  input  1  single-cycle pulse: (re)start a configuration load
- s_data_i  input  8  bitstream byte
- s_valid_i  input  1  byte valid
- s_ready_o  output  1  loader can accept a byte
- cfg_sdo_o  output  1  serial data to chain head
- cfg_shift_o  output  1  chain shift enable; chain captures cfg_sdo_o on clk_i when high
- cell_reset_no  output  1  active-low reset to all logic cells
- busy_o  output  1  load in progress (states SYNC..CHECK)
- cfg_done_o  output  1  configuration valid, cells released
- cfg_err_o  output  1  checksum failure

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active high.
- Derived constants:
  - TOTAL_BITS = NUM_CELLS*CFG_W.
  - NBYTES = ceil(TOTAL_BITS/8).
  - The bit counter is wide enough to hold TOTAL_BITS.
- Reset values:
  - state = IDLE.
  - s_ready_o, cfg_sdo_o, cfg_shift_o, busy_o, cfg_done_o, cfg_err_o = 0.
  - cell_reset_no = 0.
  - All counters and the checksum register = 0.
- Handshake:
  - A byte is accepted on a rising edge where s_valid_i & s_ready_o.
  - s_ready_o is a registered output and never depends combinationally on s_valid_i.
  - s_data_i must stay stable while s_valid_i is high and the byte has not yet been accepted.
- State machine:
  - IDLE: s_ready_o=0. start_i -> SYNC.
  - SYNC: s_ready_o=1. An accepted byte != SYNC_BYTE is discarded and the FSM stays in SYNC. An accepted SYNC_BYTE -> LOAD with bit counter and checksum cleared.
  - LOAD: s_ready_o=1. An accepted byte is XORed into the checksum, latched into a shift register, and the FSM moves to SHIFT.
  - SHIFT: s_ready_o=0, cfg_shift_o=1. cfg_sdo_o = latched byte, LSB first, one bit per cycle.
    - A byte accepted at edge T drives bit k during cycle T+1+k.
    - 8 bits are shifted, except the final byte, which shifts only TOTAL_BITS-8*(NBYTES-1) bits; its upper padding bits are never shifted but are included in the checksum.
    - When the bit counter reaches TOTAL_BITS -> CHECK; otherwise -> LOAD. s_ready_o is high again in the cycle after the last shifted bit, so back-to-back bytes can be accepted every 9 cycles.
  - CHECK: s_ready_o=1. The accepted byte is compared with the checksum. Equal -> DONE. Different -> ERR.
  - DONE: cfg_done_o=1, cell_reset_no=1, s_ready_o=0. Holds until start_i or reset_i.
  - ERR: cfg_err_o=1, cell_reset_no=0, s_ready_o=0. Holds until start_i or reset_i.
- cfg_shift_o is 0 in all states except SHIFT. cfg_sdo_o is 0 when cfg_shift_o=0.
- cell_reset_no is 0 in every state except DONE. It rises on the edge entering DONE.
- start_i has priority over everything:
  - From any state, the next state is SYNC, with cfg_done_o, cfg_err_o, counters and checksum cleared and cell_reset_no=0.
  - A start_i during SHIFT aborts the shift immediately; the partially loaded chain is overwritten by the new load.
  - s_ready_o is forced to 0 combinationally while start_i=1, so no byte is accepted in the start cycle.
- reset_i asserted mid-operation returns the block to IDLE asynchronously, with all outputs at their reset values. cell_reset_no=0 during and after reset.

Optional Feature:
- Macro: FPGA_CFG_CHECKSUM_EN.
- Defined: the CHECK state and checksum are present exactly as described above.
- Undefined: no checksum register and no CHECK state. The last SHIFT goes directly to DONE. cfg_err_o is tied to 0. The bitstream carries no checksum byte.

Test Plan (NUM_CELLS=2, CFG_W=18 -> TOTAL_BITS=36, NBYTES=5, checksum enabled unless stated):
- Reset, then idle: reset_i pulse, no start -> all outputs 0, s_ready_o=0, cell_reset_no=0, indefinitely.
- Nominal load:
  - Stimulus: start_i, bytes 0x3C,0xA5, payload 0x01,0x80,0xFF,0x00,0xF7, checksum 0x89.
  - 0x3C is dropped. Exactly 36 cfg_shift_o cycles. First sdo bits are 1,0,0,0,0,0,0,0. The final byte shifts only 4 bits: 1,1,1,0.
  - cfg_done_o=1 and cell_reset_no=1 the cycle after checksum acceptance.
- Bad checksum: same payload, checksum 0x88 -> cfg_err_o=1, cfg_done_o=0, cell_reset_no stays 0, s_ready_o=0.
- Abort: start_i asserted on the 3rd shift cycle of payload byte 2 -> cfg_shift_o drops next cycle, state SYNC, s_ready_o=1 the following cycle, and a complete new load then succeeds.
- Backpressure timing: s_valid_i held high continuously -> accepts spaced exactly 9 cycles apart. s_ready_o never high while cfg_shift_o=1.
- FPGA_CFG_CHECKSUM_EN undefined: sync + 5 payload bytes -> cfg_done_o=1 one cycle after the last shifted bit. cfg_err_o stays 0.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// ============================================================================
// fpga_cfg_loader: byte-stream to serial configuration-chain loader that holds
// the logic cells in reset until a complete, validated frame has been shifted.
// Optional checksum byte and CHECK state enabled by `define FPGA_CFG_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpga_cfg_loader #(
  parameter int          NUM_CELLS = 4,
  parameter int          CFG_W     = 18,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic       cfg_sdo_o,
  output logic       cfg_shift_o,
  output logic       cell_reset_no,
  output logic       busy_o,
  output logic       cfg_done_o,
  output logic       cfg_err_o
);

  localparam int TOTAL_BITS = NUM_CELLS * CFG_W;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef FPGA_CFG_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;
`endif

  logic [2:0]       state_q,   state_d;
  logic [7:0]       shreg_q,   shreg_d;
  logic [CNT_W-1:0] bitcnt_q,  bitcnt_d;
  logic [2:0]       bytebit_q, bytebit_d;
  logic             s_ready_q, s_ready_d;
  logic             accept;
`ifdef FPGA_CFG_CHECKSUM_EN
  logic [7:0]       csum_q,    csum_d;
`endif

  assign accept = s_valid_i & s_ready_o;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    bytebit_d = bytebit_q;
`ifdef FPGA_CFG_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (start_i) begin
      state_d   = ST_SYNC;
      shreg_d   = '0;
      bitcnt_d  = '0;
      bytebit_d = '0;
`ifdef FPGA_CFG_CHECKSUM_EN
      csum_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (accept && (s_data_i == SYNC_BYTE)) begin
            state_d  = ST_LOAD;
            bitcnt_d = '0;
`ifdef FPGA_CFG_CHECKSUM_EN
            csum_d   = '0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept) begin
            shreg_d   = s_data_i;
            bytebit_d = '0;
            state_d   = ST_SHIFT;
`ifdef FPGA_CFG_CHECKSUM_EN
            csum_d    = csum_q ^ s_data_i;
`endif
          end
        end
        ST_SHIFT: begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bitcnt_d  = bitcnt_q + 1'b1;
          bytebit_d = bytebit_q + 3'd1;
          // Final byte stops early: its padding bits never reach the chain.
          if (bitcnt_q == LAST_BIT) begin
`ifdef FPGA_CFG_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else if (bytebit_q == 3'd7) begin
            state_d = ST_LOAD;
          end
        end
`ifdef FPGA_CFG_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) state_d = (s_data_i == csum_q) ? ST_DONE : ST_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  // Ready is registered from the next state so it never follows s_valid_i.
  always_comb begin
    s_ready_d = (state_d == ST_SYNC) || (state_d == ST_LOAD);
`ifdef FPGA_CFG_CHECKSUM_EN
    s_ready_d = s_ready_d || (state_d == ST_CHECK);
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      bytebit_q <= '0;
      s_ready_q <= 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      bytebit_q <= bytebit_d;
      s_ready_q <= s_ready_d;
`ifdef FPGA_CFG_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign s_ready_o     = s_ready_q & ~start_i;
  assign cfg_shift_o   = (state_q == ST_SHIFT);
  assign cfg_sdo_o     = cfg_shift_o & shreg_q[0];
  assign cell_reset_no = (state_q == ST_DONE);
  assign cfg_done_o    = (state_q == ST_DONE);
`ifdef FPGA_CFG_CHECKSUM_EN
  assign busy_o    = (state_q == ST_SYNC) || (state_q == ST_LOAD) ||
                     (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign cfg_err_o = (state_q == ST_ERR);
`else
  assign busy_o    = (state_q == ST_SYNC) || (state_q == ST_LOAD) ||
                     (state_q == ST_SHIFT);
  assign cfg_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpga_cfg_loader.sv
// ============================================================================
// tb_fpga_cfg_loader: randomized self-checking bench for fpga_cfg_loader
// (NUM_CELLS=2, CFG_W=18), reference model built from the frame rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpga_cfg_loader;

  localparam int NUM_CELLS = 2;
  localparam int CFG_W     = 18;
  localparam int TOTAL     = NUM_CELLS * CFG_W;
  localparam int NBYTES    = (TOTAL + 7) / 8;
  localparam int NLAST     = TOTAL - 8 * (NBYTES - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       svalid = 1'b0;
  logic [7:0] sdata = 8'h00;
  logic       s_ready, sdo, shift, cell_rst_n, busy, done, err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int viol = 0;
  bit bitq[$];
  int acc_q[$];
  logic [7:0] pay [NBYTES];
  logic [TOTAL-1:0] last_bits;

  fpga_cfg_loader #(.NUM_CELLS(NUM_CELLS), .CFG_W(CFG_W), .SYNC_BYTE(8'hA5)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .s_data_i(sdata),
    .s_valid_i(svalid), .s_ready_o(s_ready), .cfg_sdo_o(sdo),
    .cfg_shift_o(shift), .cell_reset_no(cell_rst_n), .busy_o(busy),
    .cfg_done_o(done), .cfg_err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (shift) bitq.push_back(sdo);
    if (s_ready && shift) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] outs();
    return {s_ready, sdo, shift, cell_rst_n, busy, done, err};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    sdata  = b;
    svalid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      chk("accept_timeout", s_ready, 1);
    end else begin
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
    end
    svalid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bitq.delete();
    acc_q.delete();
  endtask

  task automatic run_load(input bit do_start, input int ngarb, input bit bad);
    logic [TOTAL-1:0] expv;
    logic [7:0] g;
    int p0, nbad, n;
`ifdef FPGA_CFG_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < NBYTES; i++) cs = cs ^ pay[i];
`endif
    if (do_start) pulse_start();
    for (int i = 0; i < ngarb; i++) begin
      g = (i == 0) ? 8'h3C : 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
    send_byte(8'hA5);
    p0 = acc_q.size();
    for (int i = 0; i < NBYTES; i++) send_byte(pay[i]);
`ifdef FPGA_CFG_CHECKSUM_EN
    send_byte(cs ^ {7'd0, bad});
    @(negedge clk);
    chk("done", done, !bad);
    chk("err", err, bad);
    chk("cell_rst_n", cell_rst_n, !bad);
    chk("ready_end", s_ready, 0);
`else
    if (bad) $display("note: corruption request ignored, build carries no checksum byte");
    n = 1;
    @(negedge clk);
    while (!done && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("done_latency", n, NLAST + 1);
    chk("err", err, 0);
    chk("cell_rst_n", cell_rst_n, 1);
`endif
    chk("busy_end", busy, 0);
    chk("shift_cnt", bitq.size(), TOTAL);
    for (int k = 0; k < TOTAL; k++) begin
      expv[k]      = pay[k / 8][k % 8];
      last_bits[k] = (k < bitq.size()) ? bitq[k] : 1'b0;
    end
    chk("bits", last_bits, expv);
    nbad = 0;
    if (acc_q.size() < p0 + NBYTES) nbad = 99;
    else begin
      if (acc_q[p0] - acc_q[p0 - 1] != 1) nbad++;
      for (int i = 1; i < NBYTES; i++)
        if (acc_q[p0 + i] - acc_q[p0 + i - 1] != 9) nbad++;
`ifdef FPGA_CFG_CHECKSUM_EN
      if (acc_q.size() < p0 + NBYTES + 1) nbad++;
      else if (acc_q[p0 + NBYTES] - acc_q[p0 + NBYTES - 1] != NLAST + 1) nbad++;
`endif
    end
    chk("accept_spacing", nbad, 0);
  endtask

  initial begin
    int nz;
    // reset and idle
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", outs(), 0);
    rst = 1'b0;
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (outs() != 0) nz++;
    end
    chk("idle_outs", nz, 0);

    // nominal frame
    pay[0] = 8'h01; pay[1] = 8'h80; pay[2] = 8'hFF; pay[3] = 8'h00; pay[4] = 8'hF7;
    run_load(1, 1, 0);
    chk("first8", last_bits[7:0], 8'h01);
    chk("last4", last_bits[TOTAL-1:TOTAL-4], 4'b0111);
    repeat (10) @(negedge clk);
    chk("done_hold", {done, cell_rst_n, s_ready}, 3'b110);

`ifdef FPGA_CFG_CHECKSUM_EN
    run_load(1, 0, 1);
    repeat (5) @(negedge clk);
    chk("err_hold", {err, done, cell_rst_n}, 3'b100);
`endif

    // abort on the third shift cycle of payload byte 2
    foreach (pay[i]) pay[i] = 8'($urandom);
    pulse_start();
    chk("start_clears", {done, err, cell_rst_n, busy}, 4'b0001);
    send_byte(8'hA5);
    send_byte(pay[0]);
    send_byte(pay[1]);
    send_byte(pay[2]);
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("abort_in_shift", {shift, s_ready}, 2'b10);
    @(posedge clk);
    #1 start = 1'b0;
    bitq.delete();
    acc_q.delete();
    @(negedge clk);
    chk("abort_sync", {shift, busy, s_ready}, 3'b011);
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("ready_forced_low", s_ready, 0);
    @(posedge clk);
    #1 start = 1'b0;
    bitq.delete();
    acc_q.delete();
    run_load(0, 0, 0);

    // randomized frames
    for (int it = 0; it < 6; it++) begin
      foreach (pay[i]) pay[i] = 8'($urandom);
`ifdef FPGA_CFG_CHECKSUM_EN
      run_load(1, $urandom_range(0, 3), 1'($urandom % 2));
`else
      run_load(1, $urandom_range(0, 3), 1'b0);
`endif
    end

    // asynchronous reset mid-load
    foreach (pay[i]) pay[i] = 8'($urandom);
    pulse_start();
    send_byte(8'hA5);
    send_byte(pay[0]);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", outs(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", outs(), 0);

    chk("ready_during_shift", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
